// File: rtl/alarm_tone_driver.sv
// Alarm buzzer driver: beeps a square-wave tone in an on/off cadence while the alarm request is high.
// Optional ALARM_TWO_TONE_EN: odd beats use a doubled tone half-period (warble).
module alarm_tone_driver #(
    parameter int TONE_DIV      = 10_000,
    parameter int CADENCE_CYC   = 4_000_000,
    parameter int TIMEOUT_BEATS = 50,
    parameter int DEBOUNCE_CYC  = 200_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic alarm_in,
    input  logic stop_btn,
    output logic tone_out,
    output logic ringing
);

    // state    | meaning
    // IDLE     | no alarm request, buzzer quiet
    // RING     | beeping in on/off cadence
    // SILENCED | request still high but stopped by button or timeout

`ifdef ALARM_TWO_TONE_EN
    localparam int TONE_MAX = 2 * TONE_DIV;
`else
    localparam int TONE_MAX = TONE_DIV;
`endif
    localparam int TONE_W = (TONE_MAX > 1) ? $clog2(TONE_MAX) : 1;
    localparam int CAD_W  = (CADENCE_CYC > 1) ? $clog2(CADENCE_CYC) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int BEAT_W = $clog2(TIMEOUT_BEATS) + 1;

    localparam logic [CAD_W-1:0]  CAD_LAST  = CAD_W'(CADENCE_CYC - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TIMEOUT_BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_SAT  = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RING     = 2'd1,
        SILENCED = 2'd2
    } state_t;

    state_t state, state_nx;

    logic alarm_s1, alarm_s2, alarm_d;
    logic stop_s1, stop_s2, stop_db, stop_db_d;
    logic [DEB_W-1:0]  deb_cnt;
    logic [CAD_W-1:0]  cad_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [TONE_W-1:0] tone_cnt;
    logic [TONE_W-1:0] tone_last;
    logic off_half;

    logic alarm_rise, stop_press, cad_wrap, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_s1  <= 1'b0;
            alarm_s2  <= 1'b0;
            alarm_d   <= 1'b0;
            stop_s1   <= 1'b0;
            stop_s2   <= 1'b0;
            stop_db   <= 1'b0;
            stop_db_d <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            alarm_s1  <= alarm_in;
            alarm_s2  <= alarm_s1;
            alarm_d   <= alarm_s2;
            stop_s1   <= stop_btn;
            stop_s2   <= stop_s1;
            stop_db_d <= stop_db;
            // debounced level follows only after DEBOUNCE_CYC consecutive differing samples
            if (stop_s2 == stop_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                stop_db <= stop_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign alarm_rise = alarm_s2 & ~alarm_d;
    assign stop_press = stop_db & ~stop_db_d;
    assign cad_wrap   = (cad_cnt == CAD_LAST);
    assign timeout    = cad_wrap & off_half & (beat_cnt == BEAT_LAST);

`ifdef ALARM_TWO_TONE_EN
    assign tone_last = beat_cnt[0] ? TONE_W'(2 * TONE_DIV - 1) : TONE_W'(TONE_DIV - 1);
`else
    assign tone_last = TONE_W'(TONE_DIV - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (alarm_rise) state_nx = RING;
            end
            RING: begin
                if (!alarm_s2) state_nx = IDLE;
                else if (stop_press || timeout) state_nx = SILENCED;
            end
            SILENCED: begin
                if (!alarm_s2) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ringing  <= 1'b0;
            tone_out <= 1'b0;
            cad_cnt  <= '0;
            beat_cnt <= '0;
            tone_cnt <= '0;
            off_half <= 1'b0;
        end else begin
            ringing <= (state_nx == RING);
            // everything held cleared outside RING, which also gives a clean start on entry
            if (state != RING || state_nx != RING) begin
                cad_cnt  <= '0;
                beat_cnt <= '0;
                tone_cnt <= '0;
                off_half <= 1'b0;
                tone_out <= 1'b0;
            end else if (cad_wrap) begin
                cad_cnt  <= '0;
                off_half <= ~off_half;
                if (off_half && beat_cnt != BEAT_SAT) beat_cnt <= beat_cnt + 1'b1;
                tone_cnt <= '0;
                tone_out <= 1'b0;
            end else begin
                cad_cnt <= cad_cnt + 1'b1;
                if (!off_half) begin
                    if (tone_cnt == tone_last) begin
                        tone_cnt <= '0;
                        tone_out <= ~tone_out;
                    end else begin
                        tone_cnt <= tone_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alarm_tone_driver.sv
// Directed bench for alarm_tone_driver with small timing parameters.
module tb_alarm_tone_driver;

`ifdef ALARM_TWO_TONE_EN
    localparam logic TWO_TONE = 1'b1;
`else
    localparam logic TWO_TONE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic alarm_in;
    logic stop_btn;
    logic tone_out;
    logic ringing;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic alarm;
        logic stop;
        int   adv;
        logic exp_tone;
        logic exp_ring;
    } vec_t;

    vec_t vecs[$];

    alarm_tone_driver #(
        .TONE_DIV(4),
        .CADENCE_CYC(32),
        .TIMEOUT_BEATS(3),
        .DEBOUNCE_CYC(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alarm_in(alarm_in),
        .stop_btn(stop_btn),
        .tone_out(tone_out),
        .ringing(ringing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic a, input logic s, input int adv, input logic t, input logic r);
        vec_t v;
        v.alarm = a;
        v.stop = s;
        v.adv = adv;
        v.exp_tone = t;
        v.exp_ring = r;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // k = clock edges since ringing rose
        add(1, 0,  3, 0, 1);            // k3
        add(1, 0,  1, 1, 1);            // k4 first toggle
        add(1, 0,  3, 1, 1);            // k7
        add(1, 0,  1, 0, 1);            // k8
        add(1, 0, 23, 1, 1);            // k31
        add(1, 0,  1, 0, 1);            // k32 off half
        add(1, 0, 31, 0, 1);            // k63
        add(1, 0,  1, 0, 1);            // k64 beat 1 on
        add(1, 0,  3, 0, 1);            // k67
        add(1, 0,  1, ~TWO_TONE, 1);    // k68
        add(1, 0,  4, TWO_TONE, 1);     // k72
        add(1, 0,  4, 1, 1);            // k76
        add(1, 0,  4, 0, 1);            // k80
        add(1, 0, 15, 1, 1);            // k95
        add(1, 0,  1, 0, 1);            // k96 off
        add(1, 0, 32, 0, 1);            // k128 beat 2 on
        add(1, 0,  4, 1, 1);            // k132
        add(1, 0, 59, 0, 1);            // k191 last off cycle
        add(1, 0,  1, 0, 0);            // k192 timeout
        add(1, 0, 58, 0, 0);            // stays silenced
        add(0, 0,  3, 0, 0);            // back to idle
        add(1, 0,  2, 0, 0);            // re-trigger, 2nd edge
        add(1, 0,  1, 0, 1);            // 3rd edge: k0
        add(1, 0,  5, 1, 1);            // k5
        add(0, 0,  2, 1, 1);            // drop not yet seen
        add(0, 0,  1, 0, 0);            // idle
        add(1, 0,  3, 0, 1);            // re-trigger k0
        add(1, 0,  4, 1, 1);            // k4 counters restarted
        add(1, 0,  3, 1, 1);            // k7
        add(1, 0,  1, 0, 1);            // k8

        rst_n = 1'b0;
        alarm_in = 1'b1;
        stop_btn = 1'b0;
        repeat (3) tick();
        check("reset tone_out", tone_out, 1'b0);
        check("reset ringing", ringing, 1'b0);
        rst_n = 1'b1;
        tick();
        check("edge1 ringing", ringing, 1'b0);
        tick();
        check("edge2 ringing", ringing, 1'b0);
        tick();
        check("edge3 ringing", ringing, 1'b1);
        check("edge3 tone_out", tone_out, 1'b0);

        foreach (vecs[i]) begin
            alarm_in = vecs[i].alarm;
            stop_btn = vecs[i].stop;
            repeat (vecs[i].adv) tick();
            check($sformatf("vec%0d tone_out", i), tone_out, vecs[i].exp_tone);
            check($sformatf("vec%0d ringing", i), ringing, vecs[i].exp_ring);
        end

        // bouncy stop press while ringing (k8)
        stop_btn = 1'b1;
        repeat (3) tick();
        stop_btn = 1'b0;
        repeat (3) tick();
        check("bounce ringing", ringing, 1'b1);
        stop_btn = 1'b1;
        n = 0;
        while (n < 20 && ringing) begin
            tick();
            n++;
        end
        if (n < 8 || n > 12) begin
            errors++;
            $display("FAIL stop latency: got %0d clk expected 8..12", n);
        end
        checks++;
        check("stop tone_out", tone_out, 1'b0);
        if (n < 13) repeat (13 - n) tick();
        stop_btn = 1'b0;
        repeat (20) tick();
        check("silenced ringing", ringing, 1'b0);
        check("silenced tone_out", tone_out, 1'b0);

        // stop press in SILENCED is ignored
        stop_btn = 1'b1;
        repeat (15) tick();
        stop_btn = 1'b0;
        repeat (15) tick();
        check("silenced press ringing", ringing, 1'b0);
        alarm_in = 1'b0;
        repeat (3) tick();
        check("idle ringing", ringing, 1'b0);

        // stop press landing on the timeout cycle
        alarm_in = 1'b1;
        repeat (3) tick();
        check("collide start ringing", ringing, 1'b1);
        repeat (180) tick();
        check("collide k180 ringing", ringing, 1'b1);
        tick();
        stop_btn = 1'b1;
        repeat (11) tick();
        check("collide k192 ringing", ringing, 1'b0);
        check("collide k192 tone_out", tone_out, 1'b0);
        repeat (2) tick();
        stop_btn = 1'b0;
        repeat (20) tick();
        check("collide after ringing", ringing, 1'b0);
        check("collide after tone_out", tone_out, 1'b0);

        // asynchronous reset mid-ring
        alarm_in = 1'b0;
        repeat (3) tick();
        alarm_in = 1'b1;
        repeat (3) tick();
        check("pre-reset ringing", ringing, 1'b1);
        repeat (5) tick();
        check("pre-reset tone_out", tone_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset tone_out", tone_out, 1'b0);
        check("async reset ringing", ringing, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("post-reset edge2 ringing", ringing, 1'b0);
        tick();
        check("post-reset edge3 ringing", ringing, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
